db_multi: RTL
=============

DB_MULTI -- requirements
Module: db_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent debounce channels (>=1).
REQ-002 SHALL have parameter TICK_DIV, default 100000: clk cycles per sample tick (>=1).
REQ-003 SHALL have parameter STABLE_TICKS, default 4: consecutive disagreeing ticks required to accept a new level (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel (>=2).
REQ-005 SHALL have parameter INIT_VAL [N_CH-1:0], default all 0: per-channel reset level.
REQ-006 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port raw_input  input  N_CH  asynchronous raw switch levels.
REQ-009 SHALL have port db  output  N_CH  registered debounced levels.
REQ-010 SHALL have port rise  output  N_CH  one-cycle pulse when db[i] goes 0->1.
REQ-011 SHALL have port fall  output  N_CH  one-cycle pulse when db[i] goes 1->0.
REQ-012 SHALL have port tick  output  1  one-cycle sample strobe, for observation.

Function
REQ-013 SHALL use no derived or gated clocks; tick is a clock enable only.
REQ-014 SHALL hold a prescaler of width clog2(TICK_DIV) counting 0..TICK_DIV-1 and wrapping to 0; tick=1 exactly in cycles where prescaler==TICK_DIV-1; TICK_DIV=1 gives tick=1 every cycle.
REQ-015 SHALL pass raw_input[i] through a SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-016 SHALL run one two-state FSM per channel: AGREE (cnt=0) and PENDING (cnt>0 while counting); channels fully independent.
REQ-017 SHALL, on a tick where sync[i]==db[i], force cnt[i]=0 and state AGREE (bounce discards progress).
REQ-018 SHALL, on a tick where sync[i]!=db[i] and cnt[i]<STABLE_TICKS-1, increment cnt[i] and enter/stay PENDING.
REQ-019 SHALL, on a tick where sync[i]!=db[i] and cnt[i]==STABLE_TICKS-1, register db[i]<=sync[i], cnt[i]<=0, state AGREE.
REQ-020 SHALL assert rise[i] (or fall[i]) in the same cycle db[i] first shows the new value, for exactly one cycle; rise and fall never both high on one channel.
REQ-021 SHALL leave cnt, db and state unchanged on non-tick cycles; sync changes between ticks are not observed.
REQ-022 SHALL size cnt as clog2(STABLE_TICKS)+1 bits; STABLE_TICKS=1 accepts on the first disagreeing tick.
REQ-023 SHALL bound latency from stable raw change to db change by SYNC_STAGES + STABLE_TICKS*TICK_DIV + 1 cycles.
REQ-024 SHALL allow simultaneous transitions on any subset of channels in the same cycle.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set prescaler=0, tick=0, every sync stage[i]=INIT_VAL[i], db=INIT_VAL, cnt=0, all FSMs AGREE, rise=fall=0.
REQ-026 SHALL give rst priority over tick; reset mid-PENDING discards progress and emits no pulse.
REQ-027 SHALL produce no rise/fall in the first cycles after reset when raw_input equals INIT_VAL.

Verification (N_CH=4, TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2, INIT_VAL=0)
REQ-028 Reset: rst=1 two cycles, raw=0 -> db=0000, rise=fall=0; tick first high 4th cycle after release, then every 4 cycles.
REQ-029 Clean press: raw[0]=1 held -> db[0]=1 and rise[0]=1 for one cycle on 3rd tick after sync[0]=1; db[3:1] unchanged.
REQ-030 Bounce: raw[1]=1 for 2 ticks, 0 for 1 tick, repeat 5 times -> db[1]=0 throughout, no pulses.
REQ-031 Simultaneous: db=0100 settled; raw=0010 -> same cycle db=0010, rise[1]=1, fall[2]=1.
REQ-032 Reset mid-operation: raw[3]=1, rst pulsed after 2 disagreeing ticks -> db[3]=0, no rise[3]; rise[3] after 3 further full ticks.
REQ-033 STABLE_TICKS=1 rebuild: raw[0]=1 -> db[0]=1 on first tick after sync[0]=1.

Source files
------------

// File: rtl/db_multi.sv
// rtl/db_multi.sv - multi-channel switch debouncer with a shared sample-tick prescaler
// Each channel accepts a new level only after STABLE_TICKS consecutive disagreeing ticks.
module db_multi #(
    parameter int              N_CH         = 4,
    parameter int              TICK_DIV     = 100000,
    parameter int              STABLE_TICKS = 4,
    parameter int              SYNC_STAGES  = 2,
    parameter logic [N_CH-1:0] INIT_VAL     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_input,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int            CW         = $clog2(STABLE_TICKS) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
    localparam logic [0:0]    ST_AGREE   = 1'b0;
    localparam logic [0:0]    ST_PENDING = 1'b1;

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_w;
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_w;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [CW-1:0]   progress;
    logic [N_CH-1:0] state_q, state_d;
    logic [N_CH-1:0] db_q, db_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;

    assign tick_w  = (presc_q == PRESC_LAST);
    assign presc_d = tick_w ? '0 : presc_q + PW'(1);
    assign sync_w  = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        db_d     = db_q;
        rise_d   = '0;
        fall_d   = '0;
        progress = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            // An AGREE channel has no progress regardless of what cnt holds.
            progress = (state_q[i] == ST_AGREE) ? '0 : cnt_q[i];
            if (tick_w) begin
                if (sync_w[i] == db_q[i]) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_AGREE;
                end else if (progress == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_AGREE;
                    db_d[i]    = sync_w[i];
                    rise_d[i]  = sync_w[i];
                    fall_d[i]  = ~sync_w[i];
                end else begin
                    cnt_d[i]   = progress + CW'(1);
                    state_d[i] = ST_PENDING;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INIT_VAL;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            state_q <= {N_CH{ST_AGREE}};
            db_q    <= INIT_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            presc_q   <= presc_d;
            sync_q[0] <= raw_input;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign tick = tick_w & ~rst;
    assign db   = db_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule
